// File: rtl/axi4lite_ram_slave.sv
// AXI4-Lite responder backed by a small word-addressed register RAM with byte strobes.
// Latency: BVALID one cycle after AW and W are both held; RVALID one cycle after AR.
// Backpressure: one write and one read in flight; the READYs stay low until the B/R handshake.
module axi4lite_ram_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int C_RAM_DEPTH        = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY
);

   localparam int DW       = C_S_AXI_DATA_WIDTH;
   localparam int AW       = C_S_AXI_ADDR_WIDTH;
   localparam int SW       = DW / 8;
   localparam int ADDR_LSB = $clog2(SW);
   localparam int IDXW     = $clog2(C_RAM_DEPTH);
   localparam int LIMIT_I  = C_RAM_DEPTH * SW;
   localparam logic [AW:0] LIMIT = LIMIT_I[AW:0];
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_e;
   typedef enum logic {R_IDLE, R_DATA} rstate_e;

   // Protection bits carry no meaning for a plain RAM.
   logic unused_prot;
   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   logic [DW-1:0] ram_q [C_RAM_DEPTH];

   // ---------------- write path ----------------
   wstate_e         wstate_q, wstate_d;
   logic [AW-1:0]   awaddr_q, awaddr_d;
   logic            aw_held_q, aw_held_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic            w_held_q, w_held_d;
   logic            awready_q, awready_d;
   logic            wready_q, wready_d;
   logic            bvalid_q, bvalid_d;
   logic [1:0]      bresp_q, bresp_d;

   logic            aw_hs, w_hs, b_hs, commit, w_in_range;
   logic [AW-1:0]   waddr_eff;
   logic [DW-1:0]   wdata_eff;
   logic [SW-1:0]   wstrb_eff;
   logic [IDXW-1:0] widx;

   // Either half may arrive in the commit cycle itself, so use the live bus when not yet held.
   assign aw_hs      = S_AXI_AWVALID & awready_q;
   assign w_hs       = S_AXI_WVALID & wready_q;
   assign b_hs       = bvalid_q & S_AXI_BREADY;
   assign waddr_eff  = aw_held_q ? awaddr_q : S_AXI_AWADDR;
   assign wdata_eff  = w_held_q ? wdata_q : S_AXI_WDATA;
   assign wstrb_eff  = w_held_q ? wstrb_q : S_AXI_WSTRB;
   assign commit     = (wstate_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
   assign widx       = waddr_eff[ADDR_LSB +: IDXW];
   assign w_in_range = ({1'b0, waddr_eff} < LIMIT);

   // Write FSM state register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) wstate_q <= W_IDLE;
      else          wstate_q <= wstate_d;
   end

   // Write FSM next state: commit moves to RESP, B handshake returns to IDLE.
   always_comb begin
      wstate_d = wstate_q;
      case (wstate_q)
         W_IDLE:  if (commit) wstate_d = W_RESP;
         W_RESP:  if (b_hs)   wstate_d = W_IDLE;
         default: wstate_d = W_IDLE;
      endcase
   end

   // Write FSM outputs: capture AW/W independently, raise BVALID on commit, reopen on B handshake.
   always_comb begin
      awaddr_d  = awaddr_q;
      aw_held_d = aw_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      w_held_d  = w_held_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      if (wstate_q == W_IDLE) begin
         if (aw_hs) begin
            awaddr_d  = S_AXI_AWADDR;
            aw_held_d = 1'b1;
            awready_d = 1'b0;
         end
         if (w_hs) begin
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
            w_held_d = 1'b1;
            wready_d = 1'b0;
         end
         if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_in_range ? RESP_OKAY : RESP_SLVERR;
         end
      end else if (b_hs) begin
         bvalid_d  = 1'b0;
         awready_d = 1'b1;
         wready_d  = 1'b1;
      end
   end

   // Write-side registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         awaddr_q  <= '0;
         aw_held_q <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         w_held_q  <= 1'b0;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         awaddr_q  <= awaddr_d;
         aw_held_q <= aw_held_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         w_held_q  <= w_held_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // RAM storage: cleared on reset, strobed byte writes on an in-range commit.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < C_RAM_DEPTH; i++) ram_q[i] <= '0;
      end else if (commit && w_in_range) begin
         for (int b = 0; b < SW; b++) begin
            if (wstrb_eff[b]) ram_q[widx][b*8 +: 8] <= wdata_eff[b*8 +: 8];
         end
      end
   end

   // ---------------- read path ----------------
   rstate_e         rstate_q, rstate_d;
   logic            arready_q, arready_d;
   logic            rvalid_q, rvalid_d;
   logic [1:0]      rresp_q, rresp_d;
   logic [DW-1:0]   rdata_q, rdata_d;

   logic            ar_hs, r_hs, r_in_range;
   logic [IDXW-1:0] ridx;

   assign ar_hs      = S_AXI_ARVALID & arready_q;
   assign r_hs       = rvalid_q & S_AXI_RREADY;
   assign ridx       = S_AXI_ARADDR[ADDR_LSB +: IDXW];
   assign r_in_range = ({1'b0, S_AXI_ARADDR} < LIMIT);

   // Read FSM state register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) rstate_q <= R_IDLE;
      else          rstate_q <= rstate_d;
   end

   // Read FSM next state: AR handshake moves to DATA, R handshake returns to IDLE.
   always_comb begin
      rstate_d = rstate_q;
      case (rstate_q)
         R_IDLE:  if (ar_hs) rstate_d = R_DATA;
         R_DATA:  if (r_hs)  rstate_d = R_IDLE;
         default: rstate_d = R_IDLE;
      endcase
   end

   // Read FSM outputs: sample the pre-edge RAM so a same-edge write is not yet visible.
   always_comb begin
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      if (rstate_q == R_IDLE) begin
         if (ar_hs) begin
            arready_d = 1'b0;
            rvalid_d  = 1'b1;
            rresp_d   = r_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_d   = r_in_range ? ram_q[ridx] : '0;
         end
      end else if (r_hs) begin
         rvalid_d  = 1'b0;
         arready_d = 1'b1;
      end
   end

   // Read-side registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi4lite_ram_slave.sv
// Directed bench for axi4lite_ram_slave with hand-computed expectations.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: BREADY/RREADY held high except in the stall and reset scenarios.
module tb_axi4lite_ram_slave;

   logic        ACLK;
   logic        ARESETN;
   logic [5:0]  AWADDR;
   logic [2:0]  AWPROT;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [5:0]  ARADDR;
   logic [2:0]  ARPROT;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   int checks = 0;
   int errors = 0;

   axi4lite_ram_slave #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(6),
      .C_RAM_DEPTH(4)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
      .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
      .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
      .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
      .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // AW and W together; BREADY assumed high.
   task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp, input string tag);
      AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0;
      chk({tag, " bvalid"}, 64'(BVALID), 64'd1);
      chk({tag, " bresp"}, 64'(BRESP), 64'(resp));
      step();
      chk({tag, " bvalid_clr"}, 64'(BVALID), 64'd0);
      chk({tag, " awready"}, 64'(AWREADY), 64'd1);
   endtask

   // Single read; RREADY assumed high.
   task automatic do_read(input logic [5:0] a, input logic [31:0] d, input logic [1:0] resp,
                          input string tag);
      ARADDR = a; ARVALID = 1'b1;
      step();
      ARVALID = 1'b0;
      chk({tag, " rvalid"}, 64'(RVALID), 64'd1);
      chk({tag, " rdata"}, 64'(RDATA), 64'(d));
      chk({tag, " rresp"}, 64'(RRESP), 64'(resp));
      step();
      chk({tag, " rvalid_clr"}, 64'(RVALID), 64'd0);
      chk({tag, " arready"}, 64'(ARREADY), 64'd1);
   endtask

   initial begin
      ARESETN = 1'b0;
      AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b1;
      ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b1;

      // Reset state
      step(); step();
      chk("rst awready", 64'(AWREADY), 64'd1);
      chk("rst wready", 64'(WREADY), 64'd1);
      chk("rst arready", 64'(ARREADY), 64'd1);
      chk("rst bvalid", 64'(BVALID), 64'd0);
      chk("rst rvalid", 64'(RVALID), 64'd0);
      chk("rst bresp", 64'(BRESP), 64'd0);
      chk("rst rresp", 64'(RRESP), 64'd0);
      chk("rst rdata", 64'(RDATA), 64'd0);
      ARESETN = 1'b1;
      step();

      // Basic writes and reads
      do_write(6'h0, 32'h1, 4'hF, 2'b00, "w0");
      do_write(6'h4, 32'h2, 4'hF, 2'b00, "w1");
      do_write(6'h8, 32'h3, 4'hF, 2'b00, "w2");
      do_write(6'hC, 32'h4, 4'hF, 2'b00, "w3");
      do_read(6'h0, 32'h1, 2'b00, "r0");
      do_read(6'h4, 32'h2, 2'b00, "r1");
      do_read(6'h8, 32'h3, 2'b00, "r2");
      do_read(6'hC, 32'h4, 2'b00, "r3");

      // AW three cycles ahead of W
      AWADDR = 6'h8; AWVALID = 1'b1;
      step();
      AWVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("awfirst awready", 64'(AWREADY), 64'd0);
         chk("awfirst wready", 64'(WREADY), 64'd1);
         chk("awfirst bvalid", 64'(BVALID), 64'd0);
         if (i < 2) step();
      end
      WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
      step();
      WVALID = 1'b0;
      chk("awfirst commit bvalid", 64'(BVALID), 64'd1);
      chk("awfirst commit bresp", 64'(BRESP), 64'd0);
      step();
      chk("awfirst bvalid_clr", 64'(BVALID), 64'd0);
      step();
      chk("awfirst single commit", 64'(BVALID), 64'd0);

      // W three cycles ahead of AW
      WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
      step();
      WVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("wfirst wready", 64'(WREADY), 64'd0);
         chk("wfirst awready", 64'(AWREADY), 64'd1);
         chk("wfirst bvalid", 64'(BVALID), 64'd0);
         if (i < 2) step();
      end
      AWADDR = 6'h4; AWVALID = 1'b1;
      step();
      AWVALID = 1'b0;
      chk("wfirst commit bvalid", 64'(BVALID), 64'd1);
      step();
      chk("wfirst bvalid_clr", 64'(BVALID), 64'd0);
      step();
      chk("wfirst single commit", 64'(BVALID), 64'd0);
      do_read(6'h8, 32'hDEADBEEF, 2'b00, "rb8");
      do_read(6'h4, 32'hCAFEF00D, 2'b00, "rb4");

      // Byte strobes
      do_write(6'h0, 32'h11223344, 4'hF, 2'b00, "strb full");
      do_write(6'h0, 32'hAABBCCDD, 4'b0101, 2'b00, "strb partial");
      do_read(6'h0, 32'h11BB33DD, 2'b00, "strb rd");

      // Stalled responses
      BREADY = 1'b0; RREADY = 1'b0;
      AWADDR = 6'hC; WDATA = 32'h55667788; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 6'h8; ARVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall bvalid", 64'(BVALID), 64'd1);
         chk("stall bresp", 64'(BRESP), 64'd0);
         chk("stall rvalid", 64'(RVALID), 64'd1);
         chk("stall rdata", 64'(RDATA), 64'hDEADBEEF);
         chk("stall rresp", 64'(RRESP), 64'd0);
         chk("stall awready", 64'(AWREADY), 64'd0);
         chk("stall wready", 64'(WREADY), 64'd0);
         chk("stall arready", 64'(ARREADY), 64'd0);
         step();
      end
      BREADY = 1'b1; RREADY = 1'b1;
      step();
      chk("stall bvalid_clr", 64'(BVALID), 64'd0);
      chk("stall rvalid_clr", 64'(RVALID), 64'd0);
      chk("stall awready_ret", 64'(AWREADY), 64'd1);
      chk("stall wready_ret", 64'(WREADY), 64'd1);
      chk("stall arready_ret", 64'(ARREADY), 64'd1);

      // Same-edge write and read of word 0 returns the old data
      AWADDR = 6'h0; WDATA = 32'h0BADCAFE; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 6'h0; ARVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      chk("collide bvalid", 64'(BVALID), 64'd1);
      chk("collide rdata", 64'(RDATA), 64'h11BB33DD);
      step();
      do_read(6'h0, 32'h0BADCAFE, 2'b00, "collide after");

      // Out of range
      do_write(6'h10, 32'hFFFFFFFF, 4'hF, 2'b10, "oor w");
      do_read(6'h10, 32'h0, 2'b10, "oor r");
      do_read(6'h0, 32'h0BADCAFE, 2'b00, "oor keep0");
      do_read(6'h4, 32'hCAFEF00D, 2'b00, "oor keep1");
      do_read(6'h8, 32'hDEADBEEF, 2'b00, "oor keep2");
      do_read(6'hC, 32'h55667788, 2'b00, "oor keep3");

      // Reset with both responses pending
      BREADY = 1'b0; RREADY = 1'b0;
      AWADDR = 6'h4; WDATA = 32'h99999999; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 6'h8; ARVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      chk("prerst bvalid", 64'(BVALID), 64'd1);
      chk("prerst rvalid", 64'(RVALID), 64'd1);
      ARESETN = 1'b0;
      #1;
      chk("arst bvalid", 64'(BVALID), 64'd0);
      chk("arst rvalid", 64'(RVALID), 64'd0);
      step();
      ARESETN = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
      step();
      chk("postrst awready", 64'(AWREADY), 64'd1);
      chk("postrst wready", 64'(WREADY), 64'd1);
      chk("postrst arready", 64'(ARREADY), 64'd1);
      chk("postrst bvalid", 64'(BVALID), 64'd0);
      do_read(6'h4, 32'h0, 2'b00, "postrst rd4");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi4lite_ram_slave.md
Name: axi4lite_ram_slave

Overview:
- AXI4-Lite responder (slave) backed by a small word-addressed register RAM.
- It is the target end of the master-side write/read traffic our AXI VIP benches generate.
- Write and read channels run independently. Byte strobes are honoured. Out-of-range accesses return SLVERR.
- Sits behind an interconnect or directly on a VIP master port in the block design.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; 32 or 64 only.
- C_S_AXI_ADDR_WIDTH, 6, byte-address width.
- C_RAM_DEPTH, 4, number of data words (power of two, ≥2); valid byte range is 0 to C_RAM_DEPTH*(DW/8)-1.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  AW  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  DW  write data.
- S_AXI_WSTRB  in  DW/8  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response; 00 OKAY, 10 SLVERR.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  AW  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  DW  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.

Behaviour:
- Reset (ARESETN low, asynchronous assert, synchronous-to-ACLK release):
  - Both FSMs go to IDLE.
  - AWREADY=1, WREADY=1, ARREADY=1.
  - BVALID=0, RVALID=0; BRESP=00, RRESP=00, RDATA=0.
  - All RAM words cleared to 0.
  - Any transaction in flight is dropped with no response.
- Address decode:
  - Word index = addr[ADDR_LSB +: log2(C_RAM_DEPTH)], with ADDR_LSB=log2(DW/8).
  - Low ADDR_LSB bits are ignored (unaligned accesses are treated as aligned).
  - In range iff addr < C_RAM_DEPTH*(DW/8).
- Write FSM, states IDLE and RESP:
  - IDLE: AW and W are captured independently into holding registers, in either order or in the same cycle.
  - AWREADY drops the cycle after AW is captured; WREADY drops the cycle after W is captured.
  - When both are held (including the capture cycle itself), the write commits on that edge. Only bytes with WSTRB=1 are written, and only if in range.
  - Commit edge: BVALID<=1, BRESP<=00 (in range) or 10 (out of range, RAM unchanged); state<=RESP.
  - RESP: BVALID and BRESP are held stable until BREADY. On the BVALID&BREADY edge: BVALID<=0, AWREADY<=1, WREADY<=1, state<=IDLE.
  - Minimum write latency: AW and W in the same cycle gives BVALID the next cycle.
  - Throughput is 1 write per 2 cycles when BREADY is tied high.
- Read FSM, states IDLE and DATA:
  - IDLE: ARREADY=1. On the ARVALID&ARREADY edge: ARREADY<=0; RDATA<=RAM[idx] (in range) or 0 (out of range); RRESP<=00/10; RVALID<=1; state<=DATA.
  - Read latency is 1 cycle.
  - DATA: RDATA, RRESP and RVALID are held stable until RREADY. On the RVALID&RREADY edge: RVALID<=0, ARREADY<=1, state<=IDLE.
- Read/write collision: a write commit and an AR handshake on the same edge to the same word return the pre-write data. The next read sees the new data.
- No outstanding-transaction pipelining: at most 1 write and 1 read in flight.
- VALID is never dependent on READY in the outputs. Outputs are registered; no combinational input→output paths.

Test Plan:
- Write 0x00000001..0x00000004 to 0x0,0x4,0x8,0xC, AW and W together, BREADY=1 → each BVALID 1 cycle after handshake with BRESP=00. Then read 0x0..0xC → RDATA 1,2,3,4 with RRESP=00 and RVALID 1 cycle after AR.
- AW at 0x8 presented 3 cycles before W=0xDEADBEEF, then the reverse order at 0x4 → AWREADY low while waiting; single commit per write; readback matches.
- Word 0x0 = 0x11223344, then write 0xAABBCCDD with WSTRB=0101 → readback 0x11BB33DD.
- BREADY and RREADY held low 5 cycles → BVALID/RVALID and BRESP/RDATA stable for all 5 cycles; AWREADY/ARREADY stay low until the response handshake.
- Write and read at 0x10 (C_RAM_DEPTH=4) → BRESP=10, RRESP=10, RDATA=0; words 0..3 unchanged.
- Assert ARESETN low while BVALID=1 and RVALID=1 → both drop immediately; after release all readies are 1 and a read of 0x4 returns 0.
